versat_alu: RTL and testbench
=============================

// Module: versat_alu
// PURPOSE
//  Registered 16-function integer ALU functional unit for the Versat data engine.
//  Picks two operands (A, B) from the flattened flow bus by configured slot indices.
//  Applies the configured function and registers the DATA_W-bit result onto its flow output.
//  Contains an internal combinational count-leading-zeros (CLZ) unit.
// PARAMETERS
//  DATA_W  32  operand/result width (functions below specified for 32)
//  N_W     5   slot-select width; N_SLOTS = 2**N_W words on flow_in
//  FNS_W   4   function-code width; CONF_W = 2*N_W + FNS_W
// PORTS
//  clk         in   1               single clock, all state on rising edge
//  rst         in   1               synchronous, active-low reset (sampled on rising clk)
//  flow_in     in   N_SLOTS*DATA_W  flow bus; slot s = flow_in[N_SLOTS*DATA_W-1-s*DATA_W -: DATA_W]
//  flow_out    out  DATA_W          registered ALU result
//  configdata  in   CONF_W          [CONF_W-1 -: N_W]=selA, [CONF_W-N_W-1 -: N_W]=selB, [FNS_W-1:0]=fns
// BEHAVIOUR
//  - A = slot[selA], B = slot[selB]; slot 0 is the most-significant word of flow_in.
//  - Latency 1: flow_out <= f(A,B,fns) every rising clk; configdata/flow_in are sampled each cycle.
//  - There is no enable, handshake or valid signal.
//  - Reset: rst==0 at a rising edge -> flow_out <= 0; reset overrides the computation.
//  - Function codes (all 16 defined, no default case needed):
//    0 OR: A|B
//    1 AND: A&B
//    2 MUX: A[31] ? 0 : B
//    3 XOR: A^B
//    4 SEXT8: {{24{A[7]}},A[7:0]}
//    5 SEXT16: {{16{A[15]}},A[15:0]}
//    6 SHIFTR_ARTH: A>>>1, sign bit preserved
//    7 SHIFTR_LOG: A>>1, zero fill
//    8 CMP_UNS: r=B-A; r[31] replaced by (A>B unsigned)
//    9 CMP_SIG: r=B-A; r[31] replaced by (A>B signed)
//   10 ADD: A+B mod 2^32
//   11 SUB: B-A mod 2^32
//   12 CLZ: leading zeros of A, zero-extended 6-bit count 0..32
//   13 MAX: signed max(A,B)
//   14 MIN: signed min(A,B)
//   15 ABS: A[31] ? -A : A
//  - Arithmetic wraps, no overflow flags. ABS(0x80000000) = 0x80000000.
//  - MAX/MIN with equal operands -> B.
//  - CLZ(0)=32; CLZ(0xFFFFFFFF)=0; CLZ is purely combinational, 6-bit output.
//  - selA==selB is legal (same word used for both operands).
//  - A function change takes effect on the next rising edge; there is no pipeline flush.
// TESTING
//  - Reset: hold rst=0 for 2 clocks with arbitrary inputs -> flow_out==0; release -> result appears 1 clk later.
//  - selA=0, selB=1, slot0=25, slot1=26, sweep fns 0..15 one per clk, check one clk later:
//    27,24,26,3,25,25,12,12,1,1,51,1,27,26,25,25.
//  - Signed corners: A=0xFFFFFFFF, B=1 -> MAX=1, MIN=0xFFFFFFFF, ABS=1, MUX=0, SHIFTR_ARTH=0xFFFFFFFF, SHIFTR_LOG=0x7FFFFFFF.
//  - Extension/CLZ: A=0x00008080 -> SEXT8=0xFFFFFF80, SEXT16=0xFFFF8080, CLZ=16; A=0 -> CLZ=32.
//  - CMP sign bit: A=0x80000000, B=0 -> CMP_UNS[31]=1, CMP_SIG[31]=0; ADD wrap 0xFFFFFFFF+1=0.
//  - Slot select: selA=3, selB=7 with distinct slot values -> ADD result uses slots 3 and 7; rst=0 mid-sweep -> 0 next clk.

Source files
------------

// File: rtl/versat_alu.sv
// versat_alu: registered 16-function integer ALU picking two operands from the flow bus by slot index.
module versat_alu #(
    parameter int DATA_W = 32,
    parameter int N_W = 5,
    parameter int FNS_W = 4,
    localparam int N_SLOTS = 2**N_W,
    localparam int CONF_W = 2*N_W + FNS_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_SLOTS*DATA_W-1:0] flow_in,
    output logic [DATA_W-1:0]         flow_out,
    input  logic [CONF_W-1:0]         configdata
);
    localparam int CLZ_W = $clog2(DATA_W) + 1;
    logic [DATA_W-1:0] slot [N_SLOTS];
    logic [N_W-1:0] sel_a, sel_b;
    logic [FNS_W-1:0] fns;
    logic [DATA_W-1:0] a, b, diff, res_d, flow_q;
    logic [CLZ_W-1:0] clz;
    // slot 0 is the most-significant word of the bus
    for (genvar s = 0; s < N_SLOTS; s++) begin : g_slot
        assign slot[s] = flow_in[(N_SLOTS-1-s)*DATA_W +: DATA_W];
    end
    assign sel_a = configdata[CONF_W-1 -: N_W];
    assign sel_b = configdata[CONF_W-N_W-1 -: N_W];
    assign fns = configdata[FNS_W-1:0];
    assign a = slot[sel_a];
    assign b = slot[sel_b];
    always_comb begin
        diff = b - a;
        clz = CLZ_W'(DATA_W);
        for (int i = 0; i < DATA_W; i++) if (a[i]) clz = CLZ_W'(DATA_W-1-i);
        res_d = '0;
        case (fns)
            4'd0:  res_d = a | b;
            4'd1:  res_d = a & b;
            4'd2:  res_d = a[DATA_W-1] ? '0 : b;
            4'd3:  res_d = a ^ b;
            4'd4:  res_d = {{(DATA_W-8){a[7]}}, a[7:0]};
            4'd5:  res_d = {{(DATA_W-16){a[15]}}, a[15:0]};
            4'd6:  res_d = {a[DATA_W-1], a[DATA_W-1:1]};
            4'd7:  res_d = {1'b0, a[DATA_W-1:1]};
            4'd8:  res_d = {a > b, diff[DATA_W-2:0]};
            4'd9:  res_d = {$signed(a) > $signed(b), diff[DATA_W-2:0]};
            4'd10: res_d = a + b;
            4'd11: res_d = diff;
            4'd12: res_d = {{(DATA_W-CLZ_W){1'b0}}, clz};
            4'd13: res_d = ($signed(a) > $signed(b)) ? a : b;
            4'd14: res_d = ($signed(a) < $signed(b)) ? a : b;
            4'd15: res_d = a[DATA_W-1] ? -a : a;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) flow_q <= '0;
        else flow_q <= res_d;
    end
    assign flow_out = flow_q;
endmodule

// File: tb/tb_versat_alu.sv
// tb_versat_alu: randomized and directed scoreboard bench for versat_alu against a behavioural model.
module tb_versat_alu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1023:0] flow_in = '0;
    logic [31:0] flow_out;
    logic [13:0] configdata = '0;
    logic [31:0] sl [32];
    logic [31:0] exp_q [$];
    int tag_q [$];
    int total = 0;
    int bad = 0;

    versat_alu dut (
        .clk(clk),
        .rst(rst),
        .flow_in(flow_in),
        .flow_out(flow_out),
        .configdata(configdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(logic [31:0] a, logic [31:0] b, int f);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic [31:0] r;
        int n;
        case (f)
            0: return a | b;
            1: return a & b;
            2: return (sa < 0) ? 32'd0 : b;
            3: return a ^ b;
            4: return 32'($signed(a[7:0]));
            5: return 32'($signed(a[15:0]));
            6: return 32'(sa / 2 - ((sa < 0 && sa % 2 != 0) ? 1 : 0));
            7: return a / 2;
            8: begin r = b - a; r[31] = (longint'(a) > longint'(b)); return r; end
            9: begin r = b - a; r[31] = (sa > sb); return r; end
            10: return a + b;
            11: return b - a;
            12: begin n = 0; while (n < 32 && !a[31-n]) n++; return 32'(n); end
            13: return (sa > sb) ? a : b;
            14: return (sa < sb) ? a : b;
            default: return (sa < 0) ? 32'(-sa) : a;
        endcase
    endfunction

    task automatic drive(int sa, int sb, int f, bit run);
        @(negedge clk);
        for (int s = 0; s < 32; s++) flow_in[(31-s)*32 +: 32] = sl[s];
        configdata = {5'(sa), 5'(sb), 4'(f)};
        rst = run;
    endtask

    task automatic go(int sa, int sb, int f, bit run);
        drive(sa, sb, f, run);
        exp_q.push_back(run ? model(sl[sa], sl[sb], f) : 32'd0);
        tag_q.push_back(run ? f : -1);
    endtask

    task automatic go_x(int sa, int sb, int f, logic [31:0] e);
        drive(sa, sb, f, 1'b1);
        exp_q.push_back(e);
        tag_q.push_back(f);
    endtask

    task automatic rand_slots();
        for (int s = 0; s < 32; s++) sl[s] = $urandom;
    endtask

    initial begin
        logic [31:0] e;
        int t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                total++;
                if (flow_out !== e) begin
                    bad++;
                    $display("FAIL fn%0d: got %h want %h", t, flow_out, e);
                end
            end
        end
    end

    initial begin
        int sweep [16] = '{27, 24, 26, 3, 25, 25, 12, 12, 1, 1, 51, 1, 27, 26, 25, 25};
        rand_slots();
        go($urandom_range(31), $urandom_range(31), $urandom_range(15), 1'b0);
        rand_slots();
        go($urandom_range(31), $urandom_range(31), $urandom_range(15), 1'b0);
        sl[0] = 32'd25; sl[1] = 32'd26;
        for (int f = 0; f < 16; f++) go_x(0, 1, f, 32'(sweep[f]));
        sl[0] = 32'hFFFFFFFF; sl[1] = 32'd1;
        go_x(0, 1, 13, 32'd1);
        go_x(0, 1, 14, 32'hFFFFFFFF);
        go_x(0, 1, 15, 32'd1);
        go_x(0, 1, 2, 32'd0);
        go_x(0, 1, 6, 32'hFFFFFFFF);
        go_x(0, 1, 7, 32'h7FFFFFFF);
        go_x(0, 1, 10, 32'd0);
        sl[0] = 32'h00008080;
        go_x(0, 1, 4, 32'hFFFFFF80);
        go_x(0, 1, 5, 32'hFFFF8080);
        go_x(0, 1, 12, 32'd16);
        sl[0] = 32'd0;
        go_x(0, 1, 12, 32'd32);
        sl[0] = 32'h80000000; sl[1] = 32'd0;
        go_x(0, 1, 8, 32'h80000000);
        go_x(0, 1, 9, 32'h00000000);
        go_x(0, 1, 15, 32'h80000000);
        for (int s = 0; s < 32; s++) sl[s] = 32'h1000 * (s + 1) + 32'(s);
        go_x(3, 7, 10, 32'h0000C00A);
        go_x(3, 7, 11, 32'h00004004);
        go(3, 7, 12, 1'b0);
        go_x(3, 7, 13, 32'h00008007);
        go_x(5, 5, 11, 32'd0);
        sl[2] = 32'h7FFFFFFF;
        go_x(2, 2, 13, 32'h7FFFFFFF);
        for (int i = 0; i < 400; i++) begin
            if (i % 8 == 0) rand_slots();
            if (i % 5 == 0) sl[$urandom_range(31)] = (i % 10 == 0) ? 32'h80000000 : 32'(1) << $urandom_range(31);
            go($urandom_range(31), $urandom_range(31), $urandom_range(15), ($urandom_range(15) != 0));
        end
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
